// File: rtl/el2_pkg.sv
// Shared types and constants for the PMP CSR bank and its commit sequencer.
// RV_PMP_MSECCFG_EN changes the R=0,W=1 legalisation rule.
package el2_pkg;

    typedef enum logic [1:0] {
        PMP_OFF   = 2'd0,
        PMP_TOR   = 2'd1,
        PMP_NA4   = 2'd2,
        PMP_NAPOT = 2'd3
    } el2_pmp_mode_t;

    typedef struct packed {
        logic          lock;
        logic [1:0]    rsvd;
        el2_pmp_mode_t mode;
        logic          execute;
        logic          write;
        logic          read;
    } el2_pmp_cfg_pkt_t;

    // Wide enough for PA_WIDTH up to 34 plus the carry bit.
    localparam int unsigned PMP_RANGE_W = 36;

    typedef struct packed {
        logic [PMP_RANGE_W-1:0] lo;
        logic [PMP_RANGE_W-1:0] hi;
    } el2_pmp_range_t;

    localparam logic [11:0] PMPCFG_BASE    = 12'h3A0;
    localparam logic [11:0] PMPADDR0_BASE  = 12'h3B0;
    localparam logic [11:0] PMPADDR16_BASE = 12'h3C0;
    localparam logic [11:0] PMPADDR32_BASE = 12'h3D0;
    localparam logic [11:0] PMPADDR48_BASE = 12'h3E0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DEC  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic el2_pmp_cfg_pkt_t pmp_cfg_legalize(input el2_pmp_cfg_pkt_t wr,
                                                          input el2_pmp_cfg_pkt_t old,
                                                          input int unsigned      gran);
        el2_pmp_cfg_pkt_t lg;
        lg      = wr;
        lg.rsvd = 2'b00;
`ifndef RV_PMP_MSECCFG_EN
        if (!lg.read && lg.write) begin
            lg.write = 1'b0;
        end
`endif
        if (gran >= 1 && lg.mode == PMP_NA4) begin
            lg.mode = old.mode;
        end
        return lg;
    endfunction

endpackage

// File: rtl/el2_pmp_entry_decode.sv
// Combinational decode of one PMP entry into a [lo,hi) byte range.
// Time-shared by the sequencer, one entry per cycle.
module el2_pmp_entry_decode
    import el2_pkg::*;
#(
    parameter int unsigned PA_WIDTH = 32
) (
    input  el2_pmp_mode_t         mode_i,
    input  logic                  first_i,
    input  logic [PA_WIDTH-3:0]   addr_i,
    input  logic [PA_WIDTH-3:0]   prev_addr_i,
    output el2_pmp_range_t        range_o
);

    localparam int unsigned AW = PA_WIDTH - 2;
    localparam int unsigned RW = PA_WIDTH + 1;

    logic [6:0]    k;
    logic          run;
    logic [AW-1:0] napot_mask;
    logic [RW-1:0] lo;
    logic [RW-1:0] hi;

    always_comb begin
        k   = '0;
        run = 1'b1;
        for (int j = 0; j < AW; j++) begin
            if (run && addr_i[j]) begin
                k = k + 7'd1;
            end else begin
                run = 1'b0;
            end
        end
        // All-ones address covers the whole space; clamp so hi stops at 2^PA_WIDTH.
        if (k == 7'(AW)) begin
            k = 7'(AW - 1);
        end
        napot_mask = ~((AW'(1) << (k + 7'd1)) - AW'(1));

        lo = '0;
        hi = '0;
        case (mode_i)
            PMP_NA4: begin
                lo = RW'({addr_i, 2'b00});
                hi = lo + RW'(4);
            end
            PMP_NAPOT: begin
                lo = RW'({addr_i & napot_mask, 2'b00});
                hi = lo + (RW'(1) << (k + 7'd3));
            end
            PMP_TOR: begin
                lo = first_i ? '0 : RW'({prev_addr_i, 2'b00});
                hi = RW'({addr_i, 2'b00});
            end
            default: begin
                lo = '0;
                hi = '0;
            end
        endcase

        range_o    = '0;
        range_o.lo = PMP_RANGE_W'(lo);
        range_o.hi = PMP_RANGE_W'(hi);
    end

endmodule

// File: rtl/el2_pmp_csr_seq.sv
// PMP CSR bank with a quiesce-then-decode commit sequencer producing a range table.
// Optional feature macro: RV_PMP_MSECCFG_EN (adds mseccfg, RLB lock bypass).
module el2_pmp_csr_seq
    import el2_pkg::*;
#(
    parameter int unsigned PMP_ENTRIES = 16,
    parameter int unsigned PMP_GRAN    = 0,
    parameter int unsigned PA_WIDTH    = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 csr_wen,
    output logic                                 csr_wr_ready,
    input  logic [11:0]                          csr_waddr,
    input  logic [31:0]                          csr_wdata,
    input  logic [11:0]                          csr_raddr,
    output logic [31:0]                          csr_rdata,
    output logic                                 csr_rd_hit,
    output logic                                 quiesce_req,
    input  logic                                 quiesce_ack,
    output el2_pmp_cfg_pkt_t [PMP_ENTRIES-1:0]   pmp_cfg,
    output logic [PMP_ENTRIES-1:0][PA_WIDTH:0]   pmp_lo,
    output logic [PMP_ENTRIES-1:0][PA_WIDTH:0]   pmp_hi,
    output logic                                 pmp_tbl_valid
`ifdef RV_PMP_MSECCFG_EN
    ,
    input  logic [2:0]                           mseccfg
`endif
);

    localparam int unsigned N  = PMP_ENTRIES;
    localparam int unsigned AW = PA_WIDTH - 2;
    localparam int unsigned IW = $clog2(N);
    localparam logic [31:0] NAPOT_ONES = (PMP_GRAN >= 2) ? ((32'h1 << (PMP_GRAN - 1)) - 32'h1)
                                                         : 32'h0;
    localparam logic [31:0] GRAN_MASK  = (PMP_GRAN >= 1) ? ((32'h1 << PMP_GRAN) - 32'h1) : 32'h0;

    el2_pmp_cfg_pkt_t [N-1:0]          cfg_q, cfg_d;
    logic [N-1:0][AW-1:0]              addr_q, addr_d;
    logic [N-1:0][PA_WIDTH:0]          lo_q, lo_d, hi_q, hi_d;
    logic [1:0]                        state_q, state_d;
    logic [IW-1:0]                     idx_q, idx_d;
    logic                              valid_q, valid_d;
    logic                              req_q, req_d;

    logic [11:0]    wr_off, rd_off;
    logic           wcfg_hit, waddr_hit, rcfg_hit, raddr_hit;
    logic           wr_acc, wr_hit_acc;
    logic [N-1:0]   lock_eff, addr_lock;
    logic [IW-1:0]  prev_idx;
    el2_pmp_range_t dec_range;
    logic           unused_range;

    assign wr_off     = csr_waddr - PMPADDR0_BASE;
    assign rd_off     = csr_raddr - PMPADDR0_BASE;
    assign wcfg_hit   = (csr_waddr[11:4] == PMPCFG_BASE[11:4]) && (32'(csr_waddr[3:0]) < N / 4);
    assign rcfg_hit   = (csr_raddr[11:4] == PMPCFG_BASE[11:4]) && (32'(csr_raddr[3:0]) < N / 4);
    assign waddr_hit  = (csr_waddr >= PMPADDR0_BASE) && (32'(wr_off) < N);
    assign raddr_hit  = (csr_raddr >= PMPADDR0_BASE) && (32'(rd_off) < N);
    assign wr_acc     = csr_wen && csr_wr_ready;
    assign wr_hit_acc = wr_acc && (wcfg_hit || waddr_hit);

    always_comb begin
        for (int i = 0; i < N; i++) begin
`ifdef RV_PMP_MSECCFG_EN
            lock_eff[i] = cfg_q[i].lock & ~mseccfg[2];
`else
            lock_eff[i] = cfg_q[i].lock;
`endif
        end
        // A locked TOR entry also freezes the pmpaddr below it.
        addr_lock = lock_eff;
        for (int i = 0; i < N - 1; i++) begin
            if (lock_eff[i+1] && cfg_q[i+1].mode == PMP_TOR) begin
                addr_lock[i] = 1'b1;
            end
        end
    end

`ifdef RV_PMP_MSECCFG_EN
    logic unused_mseccfg;
    assign unused_mseccfg = ^mseccfg[1:0];
`endif

    always_comb begin
        cfg_d  = cfg_q;
        addr_d = addr_q;
        if (wr_acc && wcfg_hit) begin
            for (int i = 0; i < N; i++) begin
                if (csr_waddr[3:0] == 4'(i >> 2) && !lock_eff[i]) begin
                    cfg_d[i] = pmp_cfg_legalize(el2_pmp_cfg_pkt_t'(csr_wdata[8*(i%4) +: 8]),
                                                cfg_q[i], PMP_GRAN);
                end
            end
        end
        if (wr_acc && waddr_hit) begin
            for (int i = 0; i < N; i++) begin
                if (wr_off[5:0] == 6'(i) && !addr_lock[i]) begin
                    addr_d[i] = csr_wdata[AW-1:0];
                end
            end
        end
    end

    always_comb begin
        csr_rdata  = '0;
        csr_rd_hit = rcfg_hit || raddr_hit;
        if (rcfg_hit) begin
            for (int i = 0; i < N; i++) begin
                if (csr_raddr[3:0] == 4'(i >> 2)) begin
                    csr_rdata[8*(i%4) +: 8] = cfg_q[i];
                end
            end
        end
        if (raddr_hit) begin
            for (int i = 0; i < N; i++) begin
                if (rd_off[5:0] == 6'(i)) begin
                    csr_rdata = 32'(addr_q[i]);
                    if (PMP_GRAN >= 2 && cfg_q[i].mode == PMP_NAPOT) begin
                        csr_rdata = csr_rdata | NAPOT_ONES;
                    end
                    if (PMP_GRAN >= 1 && !cfg_q[i].mode[1]) begin
                        csr_rdata = csr_rdata & ~GRAN_MASK;
                    end
                end
            end
        end
    end

    assign prev_idx = (idx_q == '0) ? '0 : idx_q - 1'b1;

    el2_pmp_entry_decode #(
        .PA_WIDTH (PA_WIDTH)
    ) u_dec (
        .mode_i      (cfg_q[idx_q].mode),
        .first_i     (idx_q == '0),
        .addr_i      (addr_q[idx_q]),
        .prev_addr_i (addr_q[prev_idx]),
        .range_o     (dec_range)
    );

    assign unused_range = ^{dec_range.lo[PMP_RANGE_W-1:PA_WIDTH+1],
                            dec_range.hi[PMP_RANGE_W-1:PA_WIDTH+1]};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        req_d   = req_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_hit_acc) begin
                    state_d = ST_REQ;
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                end
            end
            ST_REQ: begin
                if (quiesce_ack) begin
                    state_d = ST_DEC;
                    idx_d   = '0;
                end
            end
            ST_DEC: begin
                lo_d[idx_q] = dec_range.lo[PA_WIDTH:0];
                hi_d[idx_q] = dec_range.hi[PA_WIDTH:0];
                if (idx_q == IW'(N - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                valid_d = 1'b1;
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q   <= '0;
            addr_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            state_q <= ST_IDLE;
            idx_q   <= '0;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
        end else begin
            cfg_q   <= cfg_d;
            addr_q  <= addr_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            req_q   <= req_d;
        end
    end

    assign csr_wr_ready  = (state_q == ST_IDLE);
    assign quiesce_req   = req_q;
    assign pmp_tbl_valid = valid_q;
    assign pmp_cfg       = cfg_q;
    assign pmp_lo        = lo_q;
    assign pmp_hi        = hi_q;

endmodule

// File: tb/tb_el2_pmp_csr_seq.sv
// Directed bench for el2_pmp_csr_seq (16 entries, G=0, 32-bit PA).
module tb_el2_pmp_csr_seq;

    localparam int N = 16;

    logic             clk;
    logic             rst;
    logic             csr_wen;
    logic             csr_wr_ready;
    logic [11:0]      csr_waddr;
    logic [31:0]      csr_wdata;
    logic [11:0]      csr_raddr;
    logic [31:0]      csr_rdata;
    logic             csr_rd_hit;
    logic             quiesce_req;
    logic             quiesce_ack;
    logic [N-1:0][7:0]  pmp_cfg;
    logic [N-1:0][32:0] pmp_lo;
    logic [N-1:0][32:0] pmp_hi;
    logic             pmp_tbl_valid;
`ifdef RV_PMP_MSECCFG_EN
    logic [2:0]       mseccfg;
    localparam logic [7:0] EXP_B1 = 8'h02;
`else
    localparam logic [7:0] EXP_B1 = 8'h00;
`endif

    int total = 0;
    int bad   = 0;
    int ack_delay = 1;
    bit ack_en    = 1'b1;
    int ack_cnt   = 0;

    el2_pmp_csr_seq #(
        .PMP_ENTRIES (N),
        .PMP_GRAN    (0),
        .PA_WIDTH    (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .csr_wen       (csr_wen),
        .csr_wr_ready  (csr_wr_ready),
        .csr_waddr     (csr_waddr),
        .csr_wdata     (csr_wdata),
        .csr_raddr     (csr_raddr),
        .csr_rdata     (csr_rdata),
        .csr_rd_hit    (csr_rd_hit),
        .quiesce_req   (quiesce_req),
        .quiesce_ack   (quiesce_ack),
        .pmp_cfg       (pmp_cfg),
        .pmp_lo        (pmp_lo),
        .pmp_hi        (pmp_hi),
        .pmp_tbl_valid (pmp_tbl_valid)
`ifdef RV_PMP_MSECCFG_EN
        ,
        .mseccfg       (mseccfg)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // IFU/LSU stand-in: acks ack_delay cycles after quiesce_req rises.
    always @(posedge clk) begin
        #2;
        if (!quiesce_req || !ack_en) begin
            ack_cnt     = 0;
            quiesce_ack = 1'b0;
        end else begin
            ack_cnt = ack_cnt + 1;
            if (ack_cnt >= ack_delay) quiesce_ack = 1'b1;
        end
    end

    // Returns on the negedge just after the accepting posedge.
    task automatic do_write(input logic [11:0] a, input logic [31:0] d);
        int n;
        csr_waddr = a;
        csr_wdata = d;
        csr_wen   = 1'b1;
        n = 0;
        while (!csr_wr_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (csr_wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL wr_accept_timeout: addr=%h wr_ready=%b, want 1", a, csr_wr_ready);
        end
        @(negedge clk);
        csr_wen = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!pmp_tbl_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (pmp_tbl_valid !== 1'b1) begin
            bad++;
            $display("FAIL tbl_valid_timeout: tbl_valid=%b, want 1", pmp_tbl_valid);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        csr_raddr = 12'h3A0;
        #1;
        total++;
        if (csr_rdata !== 32'h0 || csr_rd_hit !== 1'b1) begin
            bad++;
            $display("FAIL reset_cfg0: rdata=%h hit=%b, want 00000000/1", csr_rdata, csr_rd_hit);
        end
        csr_raddr = 12'h3B0;
        #1;
        total++;
        if (csr_rdata !== 32'h0 || csr_rd_hit !== 1'b1) begin
            bad++;
            $display("FAIL reset_addr0: rdata=%h hit=%b, want 00000000/1", csr_rdata, csr_rd_hit);
        end
        total++;
        if (pmp_tbl_valid !== 1'b1 || csr_wr_ready !== 1'b1 || quiesce_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_status: valid=%b ready=%b req=%b, want 1/1/0",
                     pmp_tbl_valid, csr_wr_ready, quiesce_req);
        end
        csr_raddr = 12'h3A4;
        #1;
        total++;
        if (csr_rd_hit !== 1'b0 || csr_rdata !== 32'h0) begin
            bad++;
            $display("FAIL miss_cfg4: hit=%b rdata=%h, want 0/00000000", csr_rd_hit, csr_rdata);
        end
        csr_raddr = 12'h3C0;
        #1;
        total++;
        if (csr_rd_hit !== 1'b0) begin
            bad++;
            $display("FAIL miss_addr16: hit=%b, want 0", csr_rd_hit);
        end
    endtask

    task automatic test_napot;
        int n;
        int lat;
        ack_delay = 3;
        do_write(12'h3B0, 32'h0000_01FF);
        wait_valid(n);
        do_write(12'h3A0, 32'h0000_001F);
        for (int c = 0; c < 3; c++) begin
            total++;
            if (quiesce_req !== 1'b1 || pmp_tbl_valid !== 1'b0 || csr_wr_ready !== 1'b0) begin
                bad++;
                $display("FAIL napot_req_c%0d: req=%b valid=%b ready=%b, want 1/0/0",
                         c, quiesce_req, pmp_tbl_valid, csr_wr_ready);
            end
            if (c < 2) @(negedge clk);
        end
        wait_valid(n);
        lat = n + 3;
        total++;
        if (lat != 1 + 3 + N + 1) begin
            bad++;
            $display("FAIL napot_latency: got %0d cycles, want %0d", lat, 1 + 3 + N + 1);
        end
        total++;
        if (pmp_lo[0] !== 33'h0 || pmp_hi[0] !== 33'h1000 || pmp_cfg[0] !== 8'h1F) begin
            bad++;
            $display("FAIL napot_range: lo=%h hi=%h cfg=%h, want 0/1000/1f",
                     pmp_lo[0], pmp_hi[0], pmp_cfg[0]);
        end
        total++;
        if (pmp_lo[1] !== 33'h0 || pmp_hi[1] !== 33'h0) begin
            bad++;
            $display("FAIL off_range: lo=%h hi=%h, want 0/0", pmp_lo[1], pmp_hi[1]);
        end
        ack_delay = 1;
        // NA4 entry 2 plus a WARL byte 1 (reserved bits set, W without R).
        do_write(12'h3B2, 32'h0000_0100);
        wait_valid(n);
        do_write(12'h3A0, 32'h0013_621F);
        wait_valid(n);
        csr_raddr = 12'h3A0;
        #1;
        total++;
        if (csr_rdata !== {8'h00, 8'h13, EXP_B1, 8'h1F}) begin
            bad++;
            $display("FAIL cfg_warl: rdata=%h, want %h", csr_rdata, {8'h00, 8'h13, EXP_B1, 8'h1F});
        end
        total++;
        if (pmp_lo[2] !== 33'h400 || pmp_hi[2] !== 33'h404) begin
            bad++;
            $display("FAIL na4_range: lo=%h hi=%h, want 400/404", pmp_lo[2], pmp_hi[2]);
        end
    endtask

    task automatic test_tor;
        int n;
        do_write(12'h3B0, 32'h0000_0100);
        wait_valid(n);
        do_write(12'h3B1, 32'h0000_0080);
        wait_valid(n);
        do_write(12'h3A0, 32'h0013_0F1F);
        wait_valid(n);
        total++;
        if (pmp_lo[1] !== 33'h400 || pmp_hi[1] !== 33'h200) begin
            bad++;
            $display("FAIL tor_empty: lo=%h hi=%h, want 400/200", pmp_lo[1], pmp_hi[1]);
        end
        total++;
        if (pmp_lo[0] !== 33'h400 || pmp_hi[0] !== 33'h408) begin
            bad++;
            $display("FAIL napot_k0: lo=%h hi=%h, want 400/408", pmp_lo[0], pmp_hi[0]);
        end
        do_write(12'h3B1, 32'h0000_0400);
        wait_valid(n);
        total++;
        if (pmp_lo[1] !== 33'h400 || pmp_hi[1] !== 33'h1000) begin
            bad++;
            $display("FAIL tor_range: lo=%h hi=%h, want 400/1000", pmp_lo[1], pmp_hi[1]);
        end
    endtask

    task automatic test_lock;
        int n;
        do_write(12'h3A0, 32'h0013_881F);
        wait_valid(n);
        do_write(12'h3B0, 32'h0000_5555);
        total++;
        if (quiesce_req !== 1'b1 || pmp_tbl_valid !== 1'b0) begin
            bad++;
            $display("FAIL lock_addr_seq: req=%b valid=%b, want 1/0", quiesce_req, pmp_tbl_valid);
        end
        wait_valid(n);
        do_write(12'h3A0, 32'h0013_001F);
        total++;
        if (quiesce_req !== 1'b1 || pmp_tbl_valid !== 1'b0) begin
            bad++;
            $display("FAIL lock_cfg_seq: req=%b valid=%b, want 1/0", quiesce_req, pmp_tbl_valid);
        end
        wait_valid(n);
        csr_raddr = 12'h3B0;
        #1;
        total++;
        if (csr_rdata !== 32'h0000_0100) begin
            bad++;
            $display("FAIL lock_addr0: rdata=%h, want 00000100", csr_rdata);
        end
        csr_raddr = 12'h3A0;
        #1;
        total++;
        if (csr_rdata !== 32'h0013_881F) begin
            bad++;
            $display("FAIL lock_cfg0: rdata=%h, want 0013881f", csr_rdata);
        end
        total++;
        if (pmp_lo[1] !== 33'h400 || pmp_hi[1] !== 33'h1000) begin
            bad++;
            $display("FAIL lock_range: lo=%h hi=%h, want 400/1000", pmp_lo[1], pmp_hi[1]);
        end
`ifdef RV_PMP_MSECCFG_EN
        mseccfg = 3'b100;
        do_write(12'h3B0, 32'h0000_5555);
        wait_valid(n);
        do_write(12'h3A0, 32'h0013_001F);
        wait_valid(n);
        csr_raddr = 12'h3B0;
        #1;
        total++;
        if (csr_rdata !== 32'h0000_5555) begin
            bad++;
            $display("FAIL rlb_addr0: rdata=%h, want 00005555", csr_rdata);
        end
        csr_raddr = 12'h3A0;
        #1;
        total++;
        if (csr_rdata !== 32'h0013_001F) begin
            bad++;
            $display("FAIL rlb_cfg0: rdata=%h, want 0013001f", csr_rdata);
        end
`endif
    endtask

    task automatic test_back_to_back;
        int n;
        do_write(12'h3B3, 32'h0000_0010);
        repeat (2) @(negedge clk);
        csr_waddr = 12'h3B4;
        csr_wdata = 32'h0000_0020;
        csr_wen   = 1'b1;
        csr_raddr = 12'h3B4;
        #1;
        total++;
        if (csr_wr_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_ready_dec: ready=%b, want 0", csr_wr_ready);
        end
        n = 0;
        while (!csr_wr_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n != N) begin
            bad++;
            $display("FAIL b2b_stall: stalled %0d cycles, want %0d", n, N);
        end
        total++;
        if (csr_rdata !== 32'h0 || pmp_tbl_valid !== 1'b1) begin
            bad++;
            $display("FAIL b2b_pending: rdata=%h valid=%b, want 00000000/1",
                     csr_rdata, pmp_tbl_valid);
        end
        @(negedge clk);
        csr_wen = 1'b0;
        total++;
        if (quiesce_req !== 1'b1 || pmp_tbl_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second_seq: req=%b valid=%b, want 1/0", quiesce_req, pmp_tbl_valid);
        end
        wait_valid(n);
        #1;
        total++;
        if (csr_rdata !== 32'h0000_0020) begin
            bad++;
            $display("FAIL b2b_addr4: rdata=%h, want 00000020", csr_rdata);
        end
        csr_raddr = 12'h3B3;
        #1;
        total++;
        if (csr_rdata !== 32'h0000_0010) begin
            bad++;
            $display("FAIL b2b_addr3: rdata=%h, want 00000010", csr_rdata);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        ack_en = 1'b0;
        do_write(12'h3B5, 32'h0000_0033);
        repeat (2) @(negedge clk);
        total++;
        if (quiesce_req !== 1'b1 || pmp_tbl_valid !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_req: req=%b valid=%b, want 1/0", quiesce_req, pmp_tbl_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        csr_raddr = 12'h3A0;
        #1;
        total++;
        if (quiesce_req !== 1'b0 || pmp_tbl_valid !== 1'b1 || csr_wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_status: req=%b valid=%b ready=%b, want 0/1/1",
                     quiesce_req, pmp_tbl_valid, csr_wr_ready);
        end
        total++;
        if (csr_rdata !== 32'h0 || pmp_hi[1] !== 33'h0 || pmp_lo[1] !== 33'h0) begin
            bad++;
            $display("FAIL rstmid_clear: cfg0=%h lo1=%h hi1=%h, want 0/0/0",
                     csr_rdata, pmp_lo[1], pmp_hi[1]);
        end
        rst    = 1'b0;
        ack_en = 1'b1;
        // Lock from the earlier scenario must be gone after reset.
        do_write(12'h3B0, 32'h0000_0007);
        wait_valid(n);
        csr_raddr = 12'h3B0;
        #1;
        total++;
        if (csr_rdata !== 32'h0000_0007) begin
            bad++;
            $display("FAIL rstmid_unlocked: rdata=%h, want 00000007", csr_rdata);
        end
    endtask

    initial begin
        rst         = 1'b1;
        csr_wen     = 1'b0;
        csr_waddr   = '0;
        csr_wdata   = '0;
        csr_raddr   = '0;
        quiesce_ack = 1'b0;
`ifdef RV_PMP_MSECCFG_EN
        mseccfg     = 3'b000;
`endif
        test_reset();
        test_napot();
        test_tor();
        test_lock();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
